// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_controller
//  Description : Edge-latching, maskable, prioritised interrupt source for the
//                INT/NMI/INA/INTD CPU handshake with serial vector delivery.
//  Revision    : 1.0  initial release
// ============================================================================
module interrupt_controller #(
  parameter int N_SRC = 8,
  parameter int VEC_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_req,
  input  logic             nmi_req,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             eoi,
  input  logic             INA,
  output logic             INT,
  output logic             NMI,
  output logic             INTD,
  output logic [N_SRC-1:0] mask_o,
  output logic [N_SRC-1:0] pending_o,
  output logic             busy
);

  localparam int CNT_W = $clog2(VEC_W + 1);
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(VEC_W);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SEND    = 2'd2,
    SERVICE = 2'd3
  } state_t;

  state_t           r_state;
  logic [N_SRC-1:0] r_irqPrev;
  logic             r_nmiPrev;
  logic [N_SRC-1:0] r_pend;
  logic             r_nmiPend;
  logic [N_SRC-1:0] r_mask;
  logic [VEC_W-1:0] r_shift;
  logic [CNT_W-1:0] r_bitCnt;

  logic [N_SRC-1:0] w_irqRise;
  logic             w_nmiRise;
  logic [N_SRC-1:0] w_elig;
  logic             w_anyElig;
  logic             w_anyReq;
  logic [VEC_W-1:0] w_winIdx;
  logic             w_ack;
  logic [N_SRC-1:0] w_clrMask;

  assign w_irqRise = irq_req & ~r_irqPrev;
  assign w_nmiRise = nmi_req & ~r_nmiPrev;
  assign w_elig    = r_pend & ~r_mask;
  assign w_anyElig = |w_elig;
  assign w_anyReq  = r_nmiPend | w_anyElig;
  assign w_ack     = (r_state == REQ) && INA && w_anyReq;

  // Lowest eligible index wins; scanning downward lets it overwrite the rest.
  always_comb begin
    w_winIdx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_winIdx = VEC_W'(i);
      end
    end
  end

  always_comb begin
    w_clrMask = '0;
    if (w_ack && !r_nmiPend) begin
      w_clrMask = N_SRC'(1) << w_winIdx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irqPrev <= '0;
      r_nmiPrev <= 1'b0;
    end else begin
      r_irqPrev <= irq_req;
      r_nmiPrev <= nmi_req;
    end
  end

  // A new edge in the acknowledge cycle must survive the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend    <= '0;
      r_nmiPend <= 1'b0;
    end else begin
      r_pend    <= (r_pend & ~w_clrMask) | w_irqRise;
      r_nmiPend <= (r_nmiPend & ~w_ack) | w_nmiRise;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= '1;
    end else if (mask_we) begin
      r_mask <= mask_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      INT      <= 1'b0;
      NMI      <= 1'b0;
      INTD     <= 1'b0;
      busy     <= 1'b0;
      r_shift  <= '0;
      r_bitCnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_state <= REQ;
            busy    <= 1'b1;
            NMI     <= r_nmiPend;
            INT     <= ~r_nmiPend;
          end
        end
        REQ: begin
          if (!w_anyReq) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            INT     <= 1'b0;
            NMI     <= 1'b0;
          end else if (INA) begin
            r_state  <= SEND;
            INT      <= 1'b0;
            NMI      <= 1'b0;
            INTD     <= r_nmiPend;
            r_shift  <= r_nmiPend ? '0 : w_winIdx;
            r_bitCnt <= '0;
          end else begin
            INT <= ~r_nmiPend;
            NMI <= r_nmiPend;
          end
        end
        SEND: begin
          if (r_bitCnt == C_LAST_BIT) begin
            INTD    <= 1'b0;
            r_state <= SERVICE;
          end else begin
            INTD     <= r_shift[VEC_W-1];
            r_shift  <= r_shift << 1;
            r_bitCnt <= r_bitCnt + 1'b1;
          end
        end
        SERVICE: begin
          if (eoi) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign mask_o    = r_mask;
  assign pending_o = r_pend;

endmodule
`default_nettype wire
